// File: rtl/sam_pkg.sv
// Shared definitions for the sam data-memory responder: FSM encoding,
// response error code and default geometry.
package sam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } sam_state_e;

  localparam logic RSP_ERR_RANGE      = 1'b1;
  localparam int   DEFAULT_DEPTH       = 32;
  localparam int   DEFAULT_WAIT_CYCLES = 1;

endpackage

// File: rtl/sam_dmem_array.sv
// DEPTH x 32 data store: byte-enable write, combinational read,
// asynchronously cleared on reset.
module sam_dmem_array
  import sam_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/sam_dmem_responder.sv
// Slave end of the MEM-stage load/store interface: one request at a time,
// programmable wait states, then a response held until the requester takes it.
module sam_dmem_responder
  import sam_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             RN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] txn_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  sam_state_e       state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;

  // With zero wait states the array is accessed on the accept edge itself,
  // so the operation comes straight from the request port while idle.
  logic          op_live;
  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [3:0]    op_be;
  logic          op_in_range;
  logic          mem_we;
  logic          enter_resp;
  logic [31:0]   mem_rdata;

  assign op_live     = (state_q == ST_IDLE);
  assign op_we       = op_live ? req_we    : we_q;
  assign op_addr     = op_live ? req_addr  : addr_q;
  assign op_wdata    = op_live ? req_wdata : wdata_q;
  assign op_be       = op_live ? req_be    : be_q;
  assign op_in_range = (op_addr < 32'(DEPTH));

  sam_dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst   (RN),
    .we    (mem_we),
    .idx   (op_addr[AW-1:0]),
    .wdata (op_wdata),
    .be    (op_be),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    txn_count_d = txn_count_q;
    enter_resp  = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (txn_count_q != {CNT_W{1'b1}}) txn_count_d = txn_count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write commits and read data is sampled on the edge that enters RESP.
    if (enter_resp) begin
      mem_we      = op_we & op_in_range;
      rsp_rdata_d = (!op_we && op_in_range) ? mem_rdata : 32'd0;
      rsp_err_d   = op_in_range ? 1'b0 : RSP_ERR_RANGE;
    end
  end

  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_sam_dmem_responder.sv
// Bench for sam_dmem_responder: three instances (1, 3 and 0 wait states)
// share stimulus; each scenario checks the instance selected by sel.
module tb_sam_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  always #5 clk = ~clk;

  logic        rr0, rv0, re0, rr1, rv1, re1, rr2, rv2, re2;
  logic [31:0] rd0, rd1, rd2;
  logic [15:0] tc0, tc1;
  logic [3:0]  tc2;

  sam_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(1), .CNT_W(16)) dut_w1 (
    .clk(clk), .RN(rst), .req_valid(req_valid), .req_ready(rr0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv0),
    .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0), .txn_count(tc0));

  sam_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(3), .CNT_W(16)) dut_w3 (
    .clk(clk), .RN(rst), .req_valid(req_valid), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv1),
    .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1), .txn_count(tc1));

  sam_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(0), .CNT_W(4)) dut_w0 (
    .clk(clk), .RN(rst), .req_valid(req_valid), .req_ready(rr2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv2),
    .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(re2), .txn_count(tc2));

  int          sel;
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;
  logic [15:0] cur_txn, cnt_max;
  int          cur_wait;

  always_comb begin
    cur_req_ready = rr0; cur_rsp_valid = rv0; cur_rsp_err = re0;
    cur_rsp_rdata = rd0; cur_txn = tc0; cur_wait = 1; cnt_max = 16'hFFFF;
    case (sel)
      1: begin
        cur_req_ready = rr1; cur_rsp_valid = rv1; cur_rsp_err = re1;
        cur_rsp_rdata = rd1; cur_txn = tc1; cur_wait = 3;
      end
      2: begin
        cur_req_ready = rr2; cur_rsp_valid = rv2; cur_rsp_err = re2;
        cur_rsp_rdata = rd2; cur_txn = {12'd0, tc2}; cur_wait = 0; cnt_max = 16'h000F;
      end
      default: ;
    endcase
  end

  logic [32:0] exp_q[$];
  logic [31:0] model[32];
  logic [15:0] exp_cnt;
  int total = 0;
  int bad   = 0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_cnt = '0;
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall, input bit intrude);
    logic [32:0] exp, got;
    int lat;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    lat = 0;
    while (!cur_req_ready && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (!cur_req_ready) begin
      bad++; $display("FAIL req_ready_wait: got 0 expected 1 (sel=%0d)", sel);
      req_valid = 1'b0;
      return;
    end
    if (addr >= 32) exp = {1'b1, 32'd0};
    else if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) model[addr][8*b +: 8] = wdata[8*b +: 8];
      exp = {1'b0, 32'd0};
    end else exp = {1'b0, model[addr]};
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'bx;
    lat = 1;
    while (!cur_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (!cur_rsp_valid || lat != cur_wait + 1) begin
      bad++; $display("FAIL latency: got %0d valid=%b expected %0d", lat, cur_rsp_valid, cur_wait + 1);
    end
    got = {cur_rsp_err, cur_rsp_rdata};
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL rsp addr=%0d we=%b: got err/data %h expected %h", addr, we, got, exp);
    end
    if (stall > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        if (intrude) begin
          req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        end
        @(negedge clk);
        total++;
        if ({cur_rsp_valid, cur_req_ready, cur_rsp_err, cur_rsp_rdata} !== {2'b10, got}) begin
          bad++; $display("FAIL stall cycle %0d: got v=%b r=%b %h expected v=1 r=0 %h",
                          i, cur_rsp_valid, cur_req_ready, {cur_rsp_err, cur_rsp_rdata}, got);
        end
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_cnt != cnt_max) exp_cnt = exp_cnt + 1'b1;
    total++;
    if ({cur_rsp_valid, cur_req_ready, cur_txn} !== {2'b01, exp_cnt}) begin
      bad++; $display("FAIL after_handshake: got v=%b r=%b cnt=%0d expected v=0 r=1 cnt=%0d",
                      cur_rsp_valid, cur_req_ready, cur_txn, exp_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({cur_req_ready, cur_rsp_valid, cur_rsp_err, cur_rsp_rdata, cur_txn} !== {3'b100, 32'd0, 16'd0}) begin
      bad++; $display("FAIL %s (sel=%0d): got r=%b v=%b e=%b d=%h cnt=%0d expected r=1 v=0 e=0 d=0 cnt=0",
                      tag, sel, cur_req_ready, cur_rsp_valid, cur_rsp_err, cur_rsp_rdata, cur_txn);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_reset_outputs("reset_values");
    end
  endtask

  task automatic test_read_basic();
    sel = 0; do_reset();
    txn(1'b0, 32'd5, 32'd0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_write_read();
    sel = 0; do_reset();
    txn(1'b1, 32'd3, 32'hDEAD_BEEF, 4'b1111, 0, 1'b0);
    txn(1'b0, 32'd3, 32'd0, 4'h0, 0, 1'b0);
    txn(1'b1, 32'd3, 32'h0000_AA00, 4'b0010, 0, 1'b0);
    txn(1'b0, 32'd3, 32'd0, 4'h0, 0, 1'b0);
    txn(1'b1, 32'd3, 32'h1111_2222, 4'b0000, 0, 1'b0);
    txn(1'b0, 32'd3, 32'd0, 4'h0, 0, 1'b0);
    txn(1'b1, 32'd31, 32'hA5C3_0F96, 4'b1001, 0, 1'b0);
    txn(1'b0, 32'd31, 32'd0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_out_of_range();
    sel = 0; do_reset();
    txn(1'b1, 32'd1, 32'h0101_0101, 4'hF, 0, 1'b0);
    txn(1'b0, 32'd40, 32'd0, 4'h0, 0, 1'b0);
    txn(1'b1, 32'd32, 32'h5A5A_5A5A, 4'hF, 0, 1'b0);
    txn(1'b1, 32'h8000_0001, 32'h5A5A_5A5A, 4'hF, 0, 1'b0);
    for (int a = 0; a < 32; a++) txn(1'b0, 32'(a), 32'd0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 0; do_reset();
    txn(1'b1, 32'd9, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
    txn(1'b0, 32'd9, 32'd0, 4'h0, 5, 1'b1);
    txn(1'b0, 32'd9, 32'd0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int lat;
    sel = 1; do_reset();
    txn(1'b1, 32'd7, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h1234_5678; req_be = 4'hF;
    lat = 0;
    while (!cur_req_ready && lat < 20) begin @(negedge clk); lat++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if ({cur_req_ready, cur_rsp_valid} !== 2'b00) begin
      bad++; $display("FAIL in_wait: got r=%b v=%b expected r=0 v=0", cur_req_ready, cur_rsp_valid);
    end
    rst = 1'b1; #1;
    check_reset_outputs("mid_wait_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_cnt = '0;
    exp_q.delete();
    txn(1'b0, 32'd7, 32'd0, 4'h0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 2; do_reset();
    for (int i = 0; i < 20; i++) begin
      txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 35)), $urandom,
          4'($urandom_range(0, 15)), 0, 1'b0);
    end
    total++;
    if (cur_txn !== 16'h000F) begin
      bad++; $display("FAIL txn_saturate: got %0d expected 15", cur_txn);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b1; sel = 0;
    test_reset();
    test_read_basic();
    test_write_read();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
